// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device model: command encodings
// ({ncs,nras,ncas,nwe}), mode-word field positions, CAS-latency limits
// and the read-pipe entry layout.
package sdram_pkg;

    localparam logic [3:0] CMD_LOAD_MODE  = 4'b0000;
    localparam logic [3:0] CMD_REFRESH    = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_TERM = 4'b0110;
    localparam logic [3:0] CMD_NOP        = 4'b0111;

    // Mode word fields
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_BT     = 3;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_WB     = 9;

    localparam logic [2:0] CL_MIN   = 3'd2;
    localparam logic [2:0] CL_MAX   = 3'd3;
    localparam logic [2:0] CL_RESET = 3'd2;

    localparam int PIPE_DEPTH = 3;

    // Each read carries the latency it was issued with, so a later CL
    // change never retimes reads already in flight.
    typedef struct packed {
        logic        vld;
        logic [2:0]  cl;
        logic [15:0] data;
    } rd_entry_t;

    function automatic logic cl_legal(input logic [2:0] cl);
        return (cl == CL_MIN) || (cl == CL_MAX);
    endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// Read-latency pipe: a 3-deep shift register of {valid,cl,data}. An entry
// is registered onto dq_out once its age reaches its own CL-1, so the word
// is valid across edge T+CL. flush drops everything, including the bus.
module sdram_read_pipe
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [2:0]  cl,
    input  logic [15:0] data,
    output logic [15:0] dq_out,
    output logic        dq_oe
);

    rd_entry_t stage [PIPE_DEPTH];
    rd_entry_t tap;

    // Select the entry whose age matches the latency it was issued with
    always_comb begin
        tap = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (stage[i].vld && stage[i].cl == 3'(i + 2)) tap = stage[i];
        end
    end

    // Shift entries each cycle and register the matured one onto the bus
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= '0;
            dq_out <= '0;
            dq_oe  <= 1'b0;
        end else begin
            stage[0] <= '{vld: push, cl: cl, data: data};
            for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
            dq_out <= tap.data;
            dq_oe  <= tap.vld;
        end
    end

endmodule

// File: rtl/sdram_device_model.sv
// Synthesizable SDRAM chip stand-in: command decoder, per-bank open-row
// table, mode register, word array and protocol-error flag.
// Optional macro TIMING_CHECK_EN adds tRCD / tRP / double-ACTIVE / bus
// contention checks that raise err.
module sdram_device_model
    import sdram_pkg::*;
#(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int MEM_AW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_cke,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic        err,
    output logic [15:0] refresh_cnt
);

    logic [3:0]            cmd;
    logic [3:0]            bank_open;
    logic [ROW_W-1:0]      bank_row [4];
    logic [2:0]            cl_q;
    logic [3:0]            closes;
    logic [2+ROW_W+COL_W-1:0] full_addr;
    logic [MEM_AW-1:0]     mem_idx;
    logic [15:0]           rd_data;
    logic                  timing_err;
    logic                  unused_addr;
    logic [15:0]           mem [2**MEM_AW];

    // cke low masks the command; a deselected chip decodes as 1xxx (no-op)
    assign cmd         = sdram_cke ? {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} : CMD_NOP;
    assign full_addr   = {sdram_ba, bank_row[sdram_ba], sdram_a[COL_W-1:0]};
    assign mem_idx     = full_addr[MEM_AW-1:0];
    assign unused_addr = ^full_addr;
    assign rd_data     = bank_open[sdram_ba] ? mem[mem_idx] : 16'h0000;

    // Banks closed this cycle by PRECHARGE or by auto-precharge on READ/WRITE
    always_comb begin
        closes = '0;
        if (cmd == CMD_PRECHARGE)
            closes = sdram_a[10] ? 4'hF : (4'b0001 << sdram_ba);
        else if ((cmd == CMD_READ || cmd == CMD_WRITE) && sdram_a[10])
            closes = 4'b0001 << sdram_ba;
    end

    // Byte-masked array write; a closed bank leaves the array untouched
    always_ff @(posedge clk) begin
        if (!reset && cmd == CMD_WRITE && bank_open[sdram_ba]) begin
            if (!sdram_dqml) mem[mem_idx][7:0]  <= dq_in[7:0];
            if (!sdram_dqmh) mem[mem_idx][15:8] <= dq_in[15:8];
        end
    end

    // Command decode: bank table, mode register, refresh count, error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open   <= '0;
            cl_q        <= CL_RESET;
            mode_reg    <= '0;
            mode_valid  <= 1'b0;
            err         <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            case (cmd)
                CMD_ACTIVE: begin
                    bank_open[sdram_ba] <= 1'b1;
                    bank_row[sdram_ba]  <= sdram_a[ROW_W-1:0];
                end
                CMD_READ, CMD_WRITE: begin
                    if (!bank_open[sdram_ba]) err <= 1'b1;
                end
                CMD_REFRESH: begin
                    refresh_cnt <= refresh_cnt + 16'd1;
                    if (|bank_open) err <= 1'b1;
                end
                CMD_LOAD_MODE: begin
                    mode_reg <= sdram_a;
                    if (cl_legal(sdram_a[MODE_CL_MSB:MODE_CL_LSB])) begin
                        cl_q       <= sdram_a[MODE_CL_MSB:MODE_CL_LSB];
                        mode_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    if (sdram_a[MODE_BL_MSB:MODE_BL_LSB] != 3'b000) err <= 1'b1;
                end
                default: ;
            endcase
            for (int b = 0; b < 4; b++) begin
                if (closes[b]) bank_open[b] <= 1'b0;
            end
            if (timing_err) err <= 1'b1;
        end
    end

`ifdef TIMING_CHECK_EN
    // Cycles since ACTIVE (saturates at 3) and since precharge (saturates at 2)
    logic [1:0] act_age [4];
    logic [1:0] pre_age [4];

    // Age counters per bank
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                act_age[b] <= 2'd3;
                pre_age[b] <= 2'd2;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (cmd == CMD_ACTIVE && sdram_ba == 2'(b)) act_age[b] <= 2'd1;
                else if (act_age[b] != 2'd3)               act_age[b] <= act_age[b] + 2'd1;
                if (closes[b])                 pre_age[b] <= 2'd1;
                else if (pre_age[b] != 2'd2)   pre_age[b] <= pre_age[b] + 2'd1;
            end
        end
    end

    // tRCD, tRP, ACTIVE to an open bank, WRITE while we drive the bus
    always_comb begin
        timing_err = 1'b0;
        if ((cmd == CMD_READ || cmd == CMD_WRITE) && act_age[sdram_ba] < 2'd3) timing_err = 1'b1;
        if (cmd == CMD_ACTIVE && (pre_age[sdram_ba] < 2'd2 || bank_open[sdram_ba])) timing_err = 1'b1;
        if (cmd == CMD_WRITE && dq_oe) timing_err = 1'b1;
    end
`else
    assign timing_err = 1'b0;
`endif

    sdram_read_pipe u_read_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (cmd == CMD_BURST_TERM),
        .push   (cmd == CMD_READ),
        .cl     (cl_q),
        .data   (rd_data),
        .dq_out (dq_out),
        .dq_oe  (dq_oe)
    );

endmodule

// File: tb/tb_sdram_device_model.sv
// Self-checking bench for sdram_device_model: a spec-derived table of
// command/expectation records, hand sequences for multi-cycle corners and
// a randomized phase, all cross-checked against a behavioural chip model
// keyed by edge number. Honors TIMING_CHECK_EN when defined.
module tb_sdram_device_model;

    localparam logic [3:0] C_LMR = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100, C_RD  = 4'b0101, C_BT  = 4'b0110, C_NOP = 4'b0111;
`ifdef TIMING_CHECK_EN
    localparam bit TCE = 1'b1;
`else
    localparam bit TCE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1, ncs = 1'b0, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic        dqml = 1'b0, dqmh = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic        err;
    logic [15:0] refresh_cnt;

    always #5 clk = ~clk;

    sdram_device_model dut (
        .clk(clk), .reset(reset), .sdram_cke(cke), .sdram_ncs(ncs), .sdram_nras(nras),
        .sdram_ncas(ncas), .sdram_nwe(nwe), .sdram_ba(ba), .sdram_a(a),
        .sdram_dqml(dqml), .sdram_dqmh(dqmh), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .mode_reg(mode_reg), .mode_valid(mode_valid), .err(err),
        .refresh_cnt(refresh_cnt)
    );

    int n_chk = 0, n_fail = 0, ecnt = 0;

    // Reference chip model
    logic [15:0] m_mem [int];
    logic        m_open [4];
    logic [12:0] m_row [4];
    int          m_act_e [4], m_pre_e [4];
    int          m_cl;
    logic        m_err, m_mv;
    logic [15:0] m_ref;
    logic [12:0] m_mode;
    logic [15:0] exp_d [int];   // expected bus word after edge N
    bit          exp_k [int];   // entry present => dq_oe expected; value => data known

    typedef struct {
        logic [3:0] c; logic ke; logic [1:0] ba; logic [12:0] a; logic [15:0] d; logic [1:0] dqm;
        logic oe; logic [15:0] dout; logic e; logic [15:0] rf;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic m_close(input int b, input int e);
        m_open[b]  = 1'b0;
        m_pre_e[b] = e;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0; m_act_e[b] = -100; m_pre_e[b] = -100;
        end
        m_cl = 2; m_err = 0; m_mv = 0; m_ref = 0; m_mode = 0;
        exp_d.delete(); exp_k.delete();
    endtask

    task automatic model_step(input logic [3:0] c, input logic ke, input logic [1:0] b,
                              input logic [12:0] ad, input logic [15:0] d, input logic [1:0] dqm, input int e);
        int idx, ks[$];
        logic [15:0] w;
        if (!ke || c[3]) return;
        idx = (int'(b) * (1 << 22) + int'(m_row[b]) * 512 + int'(ad[8:0])) % 65536;
        case (c)
            C_ACT: begin
                if (TCE && (m_open[b] || e - m_pre_e[b] < 2)) m_err = 1;
                m_open[b] = 1; m_row[b] = ad; m_act_e[b] = e;
            end
            C_RD: begin
                if (TCE && e - m_act_e[b] < 3) m_err = 1;
                if (!m_open[b]) begin
                    m_err = 1; exp_d[e + m_cl - 1] = 16'h0; exp_k[e + m_cl - 1] = 1;
                end else if (m_mem.exists(idx)) begin
                    exp_d[e + m_cl - 1] = m_mem[idx]; exp_k[e + m_cl - 1] = 1;
                end else begin
                    exp_d[e + m_cl - 1] = 16'h0; exp_k[e + m_cl - 1] = 0;
                end
                if (ad[10]) m_close(b, e);
            end
            C_WR: begin
                if (TCE && (e - m_act_e[b] < 3 || exp_k.exists(e - 1))) m_err = 1;
                if (!m_open[b]) m_err = 1;
                else if (m_mem.exists(idx)) begin
                    w = m_mem[idx];
                    if (!dqm[0]) w[7:0]  = d[7:0];
                    if (!dqm[1]) w[15:8] = d[15:8];
                    m_mem[idx] = w;
                end else if (dqm == 2'b00) m_mem[idx] = d;
                if (ad[10]) m_close(b, e);
            end
            C_PRE: begin
                for (int i = 0; i < 4; i++) if (ad[10] || i == int'(b)) m_close(i, e);
            end
            C_REF: begin
                m_ref++;
                if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) m_err = 1;
            end
            C_LMR: begin
                m_mode = ad;
                if (ad[6:4] == 3'd2 || ad[6:4] == 3'd3) begin m_cl = int'(ad[6:4]); m_mv = 1; end
                else m_err = 1;
                if (ad[2:0] != 3'b000) m_err = 1;
            end
            C_BT: begin
                foreach (exp_k[k]) if (k >= e) ks.push_back(k);
                foreach (ks[i]) begin exp_k.delete(ks[i]); exp_d.delete(ks[i]); end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        check("dq_oe", dq_oe, exp_k.exists(ecnt));
        if (exp_k.exists(ecnt) && exp_k[ecnt]) check("dq_out", dq_out, exp_d[ecnt]);
        check("err", err, m_err);
        check("refresh_cnt", refresh_cnt, m_ref);
        check("mode_reg", mode_reg, m_mode);
        check("mode_valid", mode_valid, m_mv);
    endtask

    task automatic issue(input logic [3:0] c, input logic ke, input logic [1:0] b, input logic [12:0] ad,
                         input logic [15:0] d, input logic [1:0] dqm);
        int e = ecnt + 1;
        {ncs, nras, ncas, nwe} = c; cke = ke; ba = b; a = ad; dq_in = d; dqml = dqm[0]; dqmh = dqm[1];
        model_step(c, ke, b, ad, d, dqm, e);
        @(posedge clk); #1;
        ecnt = e;
        check_model();
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad);
        issue(c, 1'b1, b, ad, 16'h0, 2'b00);
    endtask

    task automatic nop();
        cmd(C_NOP, 2'd0, 13'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        {ncs, nras, ncas, nwe} = C_NOP; cke = 1'b1;
        @(posedge clk); #1;
        ecnt++;
        reset = 1'b0;
        model_reset();
        check("rst_dq_oe", dq_oe, 1'b0);
        check("rst_dq_out", dq_out, 16'h0);
        check("rst_err", err, 1'b0);
        check("rst_refresh", refresh_cnt, 16'h0);
        check("rst_mode_reg", mode_reg, 13'h0);
        check("rst_mode_valid", mode_valid, 1'b0);
    endtask

    function automatic void add(input logic [3:0] c, input logic ke, input logic [1:0] b, input logic [12:0] ad,
                                input logic [15:0] d, input logic [1:0] dqm, input logic oe,
                                input logic [15:0] dout, input logic e, input logic [15:0] rf);
        vec_t v;
        v = '{c: c, ke: ke, ba: b, a: ad, d: d, dqm: dqm, oe: oe, dout: dout, e: e, rf: rf};
        tbl.push_back(v);
    endfunction

    initial begin
        for (int b = 0; b < 4; b++) m_row[b] = '0;
        apply_reset();

        // Init, basic write/read, byte masks, CL=3 streaming, closed-bank read
        add(C_PRE, 1, 0, 13'h400, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(C_REF, 1, 0, 0, 0, 0, 0, 0, 0, 16'(i));
        add(C_REF, 0, 0, 0, 0, 0, 0, 0, 0, 8);          // cke low: ignored
        add(4'b1001, 1, 0, 0, 0, 0, 0, 0, 0, 8);        // deselected REFRESH: ignored
        add(C_LMR, 1, 0, 13'h220, 0, 0, 0, 0, 0, 8);
        add(C_ACT, 1, 1, 13'h0123, 0, 0, 0, 0, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        add(C_WR,  1, 1, 13'h005, 16'hA55A, 2'b00, 0, 0, 0, 8);
        add(C_RD,  1, 1, 13'h005, 0, 0, 0, 0, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 1, 16'hA55A, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        add(C_WR,  1, 1, 13'h005, 16'h1234, 2'b00, 0, 0, 0, 8);
        add(C_WR,  1, 1, 13'h005, 16'hFFEE, 2'b01, 0, 0, 0, 8);
        add(C_RD,  1, 1, 13'h005, 0, 0, 0, 0, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 1, 16'hFF34, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        add(C_LMR, 1, 0, 13'h230, 0, 0, 0, 0, 0, 8);
        for (int i = 0; i < 4; i++) add(C_WR, 1, 1, 13'(16 + i), 16'(16'h1000 * (i + 1) + i), 2'b00, 0, 0, 0, 8);
        add(C_RD,  1, 1, 13'h010, 0, 0, 0, 0, 0, 8);
        add(C_RD,  1, 1, 13'h011, 0, 0, 0, 0, 0, 8);
        add(C_RD,  1, 1, 13'h012, 0, 0, 1, 16'h1000, 0, 8);
        add(C_RD,  1, 1, 13'h013, 0, 0, 1, 16'h2001, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 1, 16'h3002, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 1, 16'h4003, 0, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        add(C_PRE, 1, 0, 13'h400, 0, 0, 0, 0, 0, 8);
        add(C_RD,  1, 0, 13'h000, 0, 0, 0, 0, 1, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 0, 0, 1, 8);
        add(C_NOP, 1, 0, 0, 0, 0, 1, 16'h0000, 1, 8);

        foreach (tbl[i]) begin
            issue(tbl[i].c, tbl[i].ke, tbl[i].ba, tbl[i].a, tbl[i].d, tbl[i].dqm);
            check($sformatf("tbl%0d_oe", i), dq_oe, tbl[i].oe);
            if (tbl[i].oe) check($sformatf("tbl%0d_dout", i), dq_out, tbl[i].dout);
            check($sformatf("tbl%0d_err", i), err, tbl[i].e);
            check($sformatf("tbl%0d_ref", i), refresh_cnt, tbl[i].rf);
        end
        check("init_mode_reg", mode_reg, 13'h230);
        check("init_mode_valid", mode_valid, 1'b1);
        apply_reset();

        // Reset while a read is in flight drops it
        cmd(C_ACT, 2, 13'h0007); nop(); nop();
        cmd(C_RD, 2, 13'h001);
        apply_reset();

        // Burst terminate, then CL change with a read in flight
        cmd(C_LMR, 0, 13'h230); cmd(C_ACT, 0, 13'h0042); nop(); nop();
        issue(C_WR, 1, 0, 13'h002, 16'hBEEF, 2'b00);
        cmd(C_RD, 0, 13'h002); cmd(C_BT, 0, 0); nop(); nop(); nop();
        cmd(C_RD, 0, 13'h002); cmd(C_LMR, 0, 13'h220); cmd(C_RD, 0, 13'h002);
        check("cl_change_first", dq_out, 16'hBEEF);
        nop(); nop(); nop();
        apply_reset();

        // Illegal CL keeps the old latency; burst length set; refresh with open bank
        cmd(C_LMR, 0, 13'h250); cmd(C_RD, 3, 13'h000); nop(); nop();
        apply_reset();
        cmd(C_LMR, 0, 13'h221); apply_reset();
        cmd(C_ACT, 1, 13'h0001); cmd(C_REF, 0, 0); apply_reset();

        // Timing checks
        cmd(C_ACT, 0, 13'h0010); cmd(C_RD, 0, 13'h000);
        check("trcd_short", err, TCE);
        apply_reset();
        cmd(C_ACT, 0, 13'h0010); nop(); nop(); cmd(C_RD, 0, 13'h000);
        check("trcd_ok", err, 1'b0);
        nop(); nop(); apply_reset();
        cmd(C_PRE, 0, 13'h000); cmd(C_ACT, 0, 13'h0001); apply_reset();
        cmd(C_ACT, 0, 13'h0001); cmd(C_ACT, 0, 13'h0002); apply_reset();
        cmd(C_ACT, 0, 13'h0001); nop(); nop(); cmd(C_RD, 0, 0); nop();
        issue(C_WR, 1, 0, 13'h000, 16'h5555, 2'b00);
        check("contention", err, TCE);
        apply_reset();

        // Randomized legal traffic
        cmd(C_LMR, 0, ($urandom_range(0, 1) != 0) ? 13'h230 : 13'h220);
        for (int b = 0; b < 4; b++) cmd(C_ACT, 2'(b), 13'($urandom_range(0, 8191)));
        nop(); nop(); nop();
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 19);
            logic [1:0]  rb = 2'($urandom_range(0, 3));
            logic [12:0] col = 13'($urandom_range(0, 7));
            if (r < 8) cmd(C_RD, rb, col);
            else if (r < 14 && !exp_k.exists(ecnt))
                issue(C_WR, 1, rb, col, 16'($urandom), 2'($urandom_range(0, 3)));
            else if (r == 18) cmd(C_LMR, 0, ($urandom_range(0, 1) != 0) ? 13'h230 : 13'h220);
            else if (r == 19) cmd(C_BT, 0, 0);
            else nop();
        end
        nop(); nop(); nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
